// File: rtl/bcd_serial_add_ctrl_pkg.sv
// Shared definitions for the digit-serial BCD adder: FSM encoding and BCD constants.
package bcd_serial_add_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic [3:0] BcdMax  = 4'd9;
  localparam logic [3:0] BcdCorr = 4'd6;

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder slice with decimal correction and invalid-digit flag.
module bcd_digit_add
  import bcd_serial_add_ctrl_pkg::*;
(
  input  logic [3:0] ad,
  input  logic [3:0] bd,
  input  logic       ci,
  output logic [3:0] d,
  output logic       co,
  output logic       bad
);

  logic [4:0] raw;

  always_comb begin
    raw = {1'b0, ad} + {1'b0, bd} + {4'd0, ci};
    d   = raw[3:0];
    co  = 1'b0;
    if (raw > {1'b0, BcdMax}) begin
      // 4-bit wrap of the corrected value is the mod-16 decimal adjust
      d  = raw[3:0] + BcdCorr;
      co = 1'b1;
    end
    bad = (ad > BcdMax) || (bd > BcdMax);
  end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder: one digit slice reused per clock, LSD first,
// with start/busy/done handshake and registered result.
module bcd_serial_add_ctrl
  import bcd_serial_add_ctrl_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  err
);

  localparam int unsigned W    = 4 * DIGITS;
  localparam int unsigned CntW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_e              state_q, state_d;
  logic [W-1:0]        a_sh_q, a_sh_d;
  logic [W-1:0]        b_sh_q, b_sh_d;
  logic [W-1:0]        res_q, res_d;
  logic                carry_q, carry_d;
  logic                err_flag_q, err_flag_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [W-1:0]        sum_q, sum_d;
  logic                cout_q, cout_d;
  logic                err_q, err_d;

  logic [3:0]          dig;
  logic                dig_co;
  logic                dig_bad;
  logic [W+3:0]        res_ins;

  bcd_digit_add u_digit (
    .ad  (a_sh_q[3:0]),
    .bd  (b_sh_q[3:0]),
    .ci  (carry_q),
    .d   (dig),
    .co  (dig_co),
    .bad (dig_bad)
  );

  // New digit enters at the top so digit 0 ends up in [3:0] after DIGITS shifts
  assign res_ins = {dig, res_q};

  always_comb begin
    state_d    = state_q;
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    res_d      = res_q;
    carry_d    = carry_q;
    err_flag_d = err_flag_q;
    cnt_d      = cnt_q;
    sum_d      = sum_q;
    cout_d     = cout_q;
    err_d      = err_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_sh_d     = a;
          b_sh_d     = b;
          carry_d    = cin;
          res_d      = '0;
          err_flag_d = 1'b0;
          cnt_d      = '0;
          state_d    = StRun;
        end
      end
      StRun: begin
        res_d      = res_ins[W+3:4];
        a_sh_d     = a_sh_q >> 4;
        b_sh_d     = b_sh_q >> 4;
        carry_d    = dig_co;
        err_flag_d = err_flag_q | dig_bad;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == CntW'(DIGITS - 1)) begin
          sum_d   = res_ins[W+3:4];
          cout_d  = dig_co;
          err_d   = err_flag_q | dig_bad;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      res_q      <= '0;
      carry_q    <= 1'b0;
      err_flag_q <= 1'b0;
      cnt_q      <= '0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_sh_q     <= a_sh_d;
      b_sh_q     <= b_sh_d;
      res_q      <= res_d;
      carry_q    <= carry_d;
      err_flag_q <= err_flag_d;
      cnt_q      <= cnt_d;
      sum_q      <= sum_d;
      cout_q     <= cout_d;
      err_q      <= err_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign err  = err_q;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Directed bench for bcd_serial_add_ctrl: vector table plus handshake/reset sequences.
module tb_bcd_serial_add_ctrl;

  localparam int D = 4;
  localparam int W = 4 * D;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         err;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  bcd_serial_add_ctrl #(.DIGITS(D)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .err   (err)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Caller guarantees the DUT is idle; inputs are scrambled right after the
  // start edge so the operation must rely on latched operands only.
  task automatic run_op(input vec_t v, input string name);
    int n;
    int busy_cnt;
    a     = v.a;
    b     = v.b;
    cin   = v.cin;
    start = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    a        = 16'h7777;
    b        = 16'h8888;
    cin      = 1'b1;
    n        = 0;
    busy_cnt = 0;
    while (!done && n < 20) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      n++;
    end
    chk({name, " latency"}, n, D);
    chk({name, " busy_cycles"}, busy_cnt, D);
    chk({name, " sum"}, {16'd0, sum}, {16'd0, v.exp_sum});
    chk({name, " cout"}, {31'd0, cout}, {31'd0, v.exp_cout});
    chk({name, " err"}, {31'd0, err}, {31'd0, v.exp_err});
    chk({name, " busy_with_done"}, {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    chk({name, " done_one_cycle"}, {31'd0, done}, 32'd0);
  endtask

  logic exp_busy;
  logic exp_done;
  int   seen;

  initial begin
    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h0958, 16'h0047, 1'b1, 16'h1006, 1'b0, 1'b0};
    vecs[3] = '{16'h12A4, 16'h0001, 1'b0, 16'h1305, 1'b0, 1'b1};
    vecs[4] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0};
    vecs[5] = '{16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0};
    vecs[6] = '{16'h5000, 16'h5000, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[8] = '{16'hFFFF, 16'h0000, 1'b0, 16'h6665, 1'b1, 1'b1};
    vecs[9] = '{16'h0009, 16'h0001, 1'b0, 16'h0010, 1'b0, 1'b0};

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset sum", {16'd0, sum}, 32'd0);
    chk("reset cout", {31'd0, cout}, 32'd0);
    chk("reset err", {31'd0, err}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // start held high: op1 1111+2222 accepted at edge 0, op2 2222+2222 only
    // after DONE has returned to IDLE (accepted at edge 6).
    a     = 16'h1111;
    b     = 16'h2222;
    cin   = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    a = 16'h2222;
    for (int k = 0; k < 12; k++) begin
      exp_busy = (k <= 3) || (k >= 6 && k <= 9);
      exp_done = (k == 4) || (k == 10);
      chk($sformatf("hold busy k%0d", k), {31'd0, busy}, {31'd0, exp_busy});
      chk($sformatf("hold done k%0d", k), {31'd0, done}, {31'd0, exp_done});
      if (k == 4) chk("hold sum1", {16'd0, sum}, 32'h3333);
      if (k >= 6 && k <= 9) chk($sformatf("hold old sum k%0d", k), {16'd0, sum}, 32'h3333);
      if (k == 10) chk("hold sum2", {16'd0, sum}, 32'h4444);
      if (k == 11) start = 1'b0;
      @(posedge clk); #1;
    end

    // Reset mid-RUN abandons the operation
    a     = 16'h9999;
    b     = 16'h0001;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("midrun busy before rst", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst sum", {16'd0, sum}, 32'd0);
    chk("rst cout", {31'd0, cout}, 32'd0);
    chk("rst err", {31'd0, err}, 32'd0);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    chk("no activity after rst", seen, 0);
    run_op(vecs[2], "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
